// File: rtl/divm_pkg.sv
// divm_pkg: shared divisor limits and clamp helper for the programmable divider.
package divm_pkg;
  localparam int MIN_DIV = 2;
  function automatic logic [31:0] div_clamp(input logic [31:0] d);
    return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
  endfunction
endpackage

// File: rtl/divm_chan.sv
// divm_chan: one divider channel with glitch-free registered clock, tick and deferred divisor reload.
module divm_chan #(
  parameter int W       = 24,
  parameter int DEF_DIV = 12000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sync,
  input  logic         wr,
  input  logic [W-1:0] wr_div,
  output logic         pend,
  output logic         clk_out,
  output logic         tick
);
  logic [W-1:0] cnt, div_act, pend_div, cnt_n, div_n;
  logic wrap, apply, last;
  always_comb begin
    wrap  = en && cnt == div_act - W'(1);
    apply = pend && (sync || wrap || !en);
    div_n = apply ? pend_div : div_act;
    cnt_n = (sync || apply || wrap) ? '0 : en ? cnt + W'(1) : cnt;
  end
  // clk_out and last are computed from next-state values so they stay aligned with cnt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div_act  <= W'(DEF_DIV);
      pend_div <= W'(DEF_DIV);
      pend     <= 1'b0;
      clk_out  <= 1'b0;
      last     <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      div_act  <= div_n;
      pend     <= wr | (pend & ~apply);
      pend_div <= wr ? wr_div : pend_div;
      clk_out  <= cnt_n >= div_n - (div_n >> 1);
      last     <= cnt_n == div_n - W'(1);
    end
  end
  assign tick = en & last;
endmodule

// File: rtl/divm_prog.sv
// divm_prog: multi-channel programmable clock divider with valid/ready divisor writes and global sync.
module divm_prog
  import divm_pkg::*;
#(
  parameter int CH      = 2,
  parameter int W       = 24,
  parameter int DEF_DIV = 12000000
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [CH-1:0]         en,
  input  logic                  sync,
  input  logic                  cfg_valid,
  input  logic [$clog2(CH):0]   cfg_ch,
  input  logic [W-1:0]          cfg_div,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  output logic [CH-1:0]         clk_out,
  output logic [CH-1:0]         tick
);
  localparam int CW = $clog2(CH) + 1;
  localparam int NP = 2 ** CW;
  logic [CH-1:0] pend;
  logic [NP-1:0] pend_ext;
  logic [W-1:0]  wr_div;
  logic          accept, in_range;
  // zero-extended so out-of-range channels read as not pending (always ready)
  assign pend_ext  = NP'(pend);
  assign cfg_ready = ~pend_ext[cfg_ch];
  assign in_range  = cfg_ch < CW'(CH);
  assign accept    = cfg_valid & cfg_ready;
  assign wr_div    = W'(div_clamp(32'(cfg_div)));
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= accept & (~in_range | (32'(cfg_div) < 32'(MIN_DIV)));
  end
  for (genvar i = 0; i < CH; i++) begin : g_chan
    divm_chan #(.W(W), .DEF_DIV(DEF_DIV)) u_chan (
      .clk     (clk_in),
      .rst     (rst),
      .en      (en[i]),
      .sync    (sync),
      .wr      (accept && cfg_ch == CW'(i)),
      .wr_div  (wr_div),
      .pend    (pend[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end
endmodule

// File: tb/tb_divm_prog.sv
// tb_divm_prog: table-driven per-cycle vectors with a scoreboard queue, plus sync/hold/reset sequences.
module tb_divm_prog;
  logic       clk_in = 0, rst = 1, sync = 0, cfg_valid = 0;
  logic [1:0] en = 0, cfg_ch = 0;
  logic [3:0] cfg_div = 0;
  logic       cfg_ready, cfg_err;
  logic [1:0] clk_out, tick;
  int checks = 0, failures = 0;

  divm_prog #(.CH(2), .W(4), .DEF_DIV(3)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .sync(sync), .cfg_valid(cfg_valid),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .clk_out(clk_out), .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0] en; logic sync; logic v; logic [1:0] ch; logic [3:0] div;
    logic rdy; logic [1:0] clk; logic [1:0] tk; logic err;
  } vec_t;
  typedef struct { logic [1:0] clk; logic [1:0] tk; logic err; } exp_t;
  vec_t vq[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    en = v.en; sync = v.sync; cfg_valid = v.v; cfg_ch = v.ch; cfg_div = v.div;
    #1;
    check({tag, " ready"}, {3'b0, cfg_ready}, {3'b0, v.rdy});
    sb.push_back('{v.clk, v.tk, v.err});
    @(posedge clk_in);
    #1;
    e = sb.pop_front();
    check({tag, " clk_out"}, {2'b0, clk_out}, {2'b0, e.clk});
    check({tag, " tick"}, {2'b0, tick}, {2'b0, e.tk});
    check({tag, " cfg_err"}, {3'b0, cfg_err}, {3'b0, e.err});
  endtask

  function automatic vec_t mk(input logic [1:0] e, input logic s, input logic v, input logic [1:0] ch,
                              input logic [3:0] d, input logic r, input logic [1:0] c, input logic [1:0] t,
                              input logic er);
    vec_t x;
    x.en = e; x.sync = s; x.v = v; x.ch = ch; x.div = d; x.rdy = r; x.clk = c; x.tk = t; x.err = er;
    return x;
  endfunction

  initial begin
    vec_t v;
    logic [1:0] prev;
    int coin;
    // default pattern after reset
    vq.push_back(mk(3,0,0,0,0,1,0,0,0)); vq.push_back(mk(3,0,0,0,0,1,3,3,0));
    vq.push_back(mk(3,0,0,0,0,1,0,0,0)); vq.push_back(mk(3,0,0,0,0,1,0,0,0));
    vq.push_back(mk(3,0,0,0,0,1,3,3,0)); vq.push_back(mk(3,0,0,0,0,1,0,0,0));
    // ch0 -> div 4 mid-period
    vq.push_back(mk(3,0,0,0,0,1,0,0,0)); vq.push_back(mk(3,0,1,0,4,1,3,3,0));
    vq.push_back(mk(3,0,0,0,0,0,0,0,0)); vq.push_back(mk(3,0,0,0,0,1,0,0,0));
    vq.push_back(mk(3,0,0,0,0,1,3,2,0)); vq.push_back(mk(3,0,0,0,0,1,1,1,0));
    vq.push_back(mk(3,0,0,0,0,1,0,0,0)); vq.push_back(mk(3,0,0,0,0,1,2,2,0));
    vq.push_back(mk(3,0,0,0,0,1,1,0,0)); vq.push_back(mk(3,0,0,0,0,1,1,1,0));
    // ch1 -> div 5, second write stalls until wrap
    vq.push_back(mk(3,0,1,1,5,1,2,2,0)); vq.push_back(mk(3,0,1,1,4,0,0,0,0));
    vq.push_back(mk(3,0,1,1,4,1,1,0,0)); vq.push_back(mk(3,0,0,1,0,0,1,1,0));
    vq.push_back(mk(3,0,0,1,0,0,2,0,0)); vq.push_back(mk(3,0,0,1,0,0,2,2,0));
    vq.push_back(mk(3,0,0,1,0,0,1,0,0)); vq.push_back(mk(3,0,0,1,0,1,1,1,0));
    vq.push_back(mk(3,0,0,1,0,1,2,0,0)); vq.push_back(mk(3,0,0,1,0,1,2,2,0));
    vq.push_back(mk(3,0,0,1,0,1,1,0,0));
    // clamp of div 0 and out-of-range channel
    vq.push_back(mk(3,0,1,0,0,1,1,1,1)); vq.push_back(mk(3,0,0,0,0,0,2,0,0));
    vq.push_back(mk(3,0,0,0,0,1,3,3,0)); vq.push_back(mk(3,0,0,0,0,1,0,0,0));
    vq.push_back(mk(3,0,1,2,7,1,1,1,1)); vq.push_back(mk(3,0,0,0,0,1,2,0,0));
    vq.push_back(mk(3,0,0,0,0,1,3,3,0)); vq.push_back(mk(3,0,0,0,0,1,0,0,0));
    // ch0 -> div 3, drift, then sync
    vq.push_back(mk(3,0,1,0,3,1,1,1,0)); vq.push_back(mk(3,0,0,0,0,0,2,0,0));
    vq.push_back(mk(3,0,0,0,0,1,2,2,0)); vq.push_back(mk(3,0,0,0,0,1,1,1,0));
    vq.push_back(mk(3,1,0,0,0,1,0,0,0));

    #3;
    check("reset clk_out", {2'b0, clk_out}, 4'h0);
    check("reset tick", {2'b0, tick}, 4'h0);
    check("reset cfg_err", {3'b0, cfg_err}, 4'h0);
    check("reset ready", {3'b0, cfg_ready}, 4'h1);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst = 0;
    for (int i = 0; i < vq.size(); i++) step(vq[i], $sformatf("vec%0d", i));

    // after sync: ch0 div3 and ch1 div4 rise together every 12 cycles
    prev = clk_out; coin = 0;
    for (int k = 1; k <= 26; k++) begin
      v = mk(3, 0, 0, 0, 0, 1, {2'((k % 4) >= 2), 1'((k % 3) == 2)},
             {2'((k % 4) == 3), 1'((k % 3) == 2)}, 0);
      step(v, $sformatf("sync k%0d", k));
      if (&(clk_out & ~prev)) begin
        coin++;
        check("coincide phase", 4'(k % 12), 4'd2);
      end
      prev = clk_out;
    end
    check("coincide count", 4'(coin), 4'd3);

    // ch0 disabled at its last count: holds, no tick
    for (int k = 27; k <= 31; k++) begin
      v = mk(2, 0, 0, 0, 0, 1, {2'((k % 4) >= 2), 1'b1}, {2'((k % 4) == 3), 1'b0}, 0);
      step(v, $sformatf("hold k%0d", k));
    end

    // async reset mid-period
    #3 rst = 1;
    #1;
    check("async clk_out", {2'b0, clk_out}, 4'h0);
    check("async tick", {2'b0, tick}, 4'h0);
    check("async cfg_err", {3'b0, cfg_err}, 4'h0);
    @(posedge clk_in);
    @(negedge clk_in);
    rst = 0;
    for (int k = 1; k <= 6; k++) begin
      v = mk(3, 0, 0, 0, 0, 1, {2{1'((k % 3) == 2)}}, {2{1'((k % 3) == 2)}}, 0);
      step(v, $sformatf("post-rst k%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
